tick_divider: RTL
=================

Name: tick_divider

Overview:
Parameterised tick divider. Counts qualifying input ticks (for example a 100 ms strobe) and emits a one-clock terminal-count pulse after exactly N ticks, where N is runtime-programmable. Supports periodic and one-shot modes, start/stop control, and a live count readout. Intended as the general building block for the game's timing chain (100 ms → 1 s, dot/dash windows).

Parameters:
DIV_WIDTH, 4, width of the tick counter and of div_val (maximum N = 2^DIV_WIDTH - 1)
DEFAULT_DIV, 10, divide value used when div_val is 0 at start; must be in 1..2^DIV_WIDTH-1

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  synchronous reset, active-high
tick_in  input  1  single-cycle tick strobe to be counted
start  input  1  pulse: latch div_val and oneshot, clear count, enter RUN
stop  input  1  pulse: abort counting, return to IDLE
oneshot  input  1  sampled at start: 1 = one-shot, 0 = periodic
div_val  input  DIV_WIDTH  divide value N, sampled at start; 0 selects DEFAULT_DIV
count  output  DIV_WIDTH  ticks seen in the current period (0..N-1)
tc_pulse  output  1  one-clock pulse when the Nth tick of a period is counted
busy  output  1  high in RUN
done  output  1  high in DONE (one-shot completed); held until start, stop or rst

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, count=0, tc_pulse=0, busy=0, done=0. Latched N=DEFAULT_DIV, latched mode=periodic. Reset overrides all other inputs, including mid-period.
- Registered outputs. busy=(state==RUN); done=(state==DONE).
- FSM states: IDLE, RUN, DONE.
  - IDLE: start → RUN.
  - RUN, periodic: terminal tick → stays in RUN.
  - RUN, one-shot: terminal tick → DONE.
  - RUN: stop → IDLE.
  - DONE: start → RUN; stop → IDLE.
- Start:
  - On start=1 (and stop=0), latch N = (div_val==0) ? DEFAULT_DIV : div_val, and latch oneshot.
  - count←0 and state←RUN on the next edge.
  - A tick_in coincident with start is ignored.
  - Start while already in RUN restarts the period and relatches N and mode. No tc_pulse is issued for the aborted period.
- Stop:
  - stop=1 forces state←IDLE and count←0; any coincident tick_in is ignored.
  - stop wins over start when both are asserted.
  - In IDLE, stop has no effect.
- Counting (RUN only):
  - tick_in=1 with count<N-1: count←count+1.
  - tick_in=1 with count==N-1 (terminal tick): count←0 and tc_pulse←1 for exactly one cycle. tc_pulse is visible the cycle after the terminal tick.
  - Periodic mode: exactly one tc_pulse per N ticks, no dropped or extra ticks across the wrap.
  - Edge case N=1: every tick produces a tc_pulse, and count stays 0.
- Unsigned arithmetic; the counter never exceeds N-1. tc_pulse=0 in every cycle not listed above.
- tick_in is ignored in IDLE and DONE, and count holds at 0 in both.
- Back-to-back ticks (tick_in high on consecutive clocks) are each counted.

Optional Feature:
TICKDIV_PERIOD_CNT_EN
- Defined:
  - Adds output period_cnt[7:0] = number of tc_pulses since the last start.
  - Saturates at 255.
  - Cleared to 0 by rst and by start.
  - Increments on the same edge that raises tc_pulse.
  - Holds its value through stop and DONE.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
1. Reset: rst=1 for 2 clocks while start=1 and tick_in=1 → count=0, tc_pulse=0, busy=0, done=0; no state change until rst=0.
2. Periodic, div_val=3, oneshot=0, start, then 9 ticks spaced 4 clocks apart → count sequence 1,2,0 repeating; exactly 3 one-clock tc_pulses, each one cycle after ticks 3, 6 and 9; busy=1 throughout.
3. One-shot, div_val=0 (DEFAULT_DIV=10), 12 ticks → tc_pulse once after tick 10; done=1 and busy=0 afterwards; ticks 11–12 ignored with count=0; a later start clears done.
4. Back-to-back: div_val=2, tick_in held high for 6 clocks → tc_pulse on cycles 2, 4 and 6 relative to the first tick (one cycle after ticks 2, 4, 6); div_val=1 → tc_pulse every cycle.
5. Control collisions:
   - Mid-period start with new div_val=5 → count←0, no pulse, next pulse after 5 ticks.
   - start+stop together → IDLE.
   - stop coincident with the terminal tick → no tc_pulse, count=0.
   - rst during RUN at count=2 → all outputs return to reset values.
6. With TICKDIV_PERIOD_CNT_EN: N=1, 300 ticks → period_cnt saturates at 255; start → period_cnt=0.

Source files
------------

// File: rtl/tick_divider.sv
// Runtime-programmable tick divider: counts tick_in strobes and pulses tc_pulse every N ticks.
// Optional `TICKDIV_PERIOD_CNT_EN adds a saturating period_cnt output of tc_pulses since start.
module tick_divider #(
    parameter int DIV_WIDTH   = 4,
    parameter int DEFAULT_DIV = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_in,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 oneshot,
    input  logic [DIV_WIDTH-1:0] div_val,
    output logic [DIV_WIDTH-1:0] count,
    output logic                 tc_pulse,
    output logic                 busy,
`ifdef TICKDIV_PERIOD_CNT_EN
    output logic [7:0]           period_cnt,
`endif
    output logic                 done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [DIV_WIDTH-1:0] DEF_N = DIV_WIDTH'(DEFAULT_DIV);
    localparam logic [DIV_WIDTH-1:0] ONE   = DIV_WIDTH'(1);

    logic [1:0]           r_state;
    logic [DIV_WIDTH-1:0] r_count;
    logic [DIV_WIDTH-1:0] r_n;
    logic                 r_oneshot;
    logic                 r_tc;
    logic                 r_busy;
    logic                 r_done;

    logic [1:0]           w_state_next;
    logic [DIV_WIDTH-1:0] w_count_next;
    logic [DIV_WIDTH-1:0] w_n_next;
    logic                 w_oneshot_next;
    logic                 w_tc_next;
    logic                 w_last;

    // r_n is never zero, so r_n - 1 cannot underflow.
    assign w_last = (r_count == (r_n - ONE));

    always_comb begin
        w_state_next   = r_state;
        w_count_next   = r_count;
        w_n_next       = r_n;
        w_oneshot_next = r_oneshot;
        w_tc_next      = 1'b0;
        if (stop) begin
            w_state_next = ST_IDLE;
            w_count_next = '0;
        end else if (start) begin
            w_n_next       = (div_val == '0) ? DEF_N : div_val;
            w_oneshot_next = oneshot;
            w_count_next   = '0;
            w_state_next   = ST_RUN;
        end else if ((r_state == ST_RUN) && tick_in) begin
            if (w_last) begin
                w_count_next = '0;
                w_tc_next    = 1'b1;
                if (r_oneshot) begin
                    w_state_next = ST_DONE;
                end
            end else begin
                w_count_next = r_count + ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_count   <= '0;
            r_n       <= DEF_N;
            r_oneshot <= 1'b0;
            r_tc      <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_count   <= w_count_next;
            r_n       <= w_n_next;
            r_oneshot <= w_oneshot_next;
            r_tc      <= w_tc_next;
            r_busy    <= (w_state_next == ST_RUN);
            r_done    <= (w_state_next == ST_DONE);
        end
    end

`ifdef TICKDIV_PERIOD_CNT_EN
    logic [7:0] r_period_cnt;

    // Advances on the same edge that raises tc_pulse; stop leaves it untouched.
    always_ff @(posedge clk) begin
        if (rst || (start && !stop)) begin
            r_period_cnt <= 8'd0;
        end else if (w_tc_next && (r_period_cnt != 8'hFF)) begin
            r_period_cnt <= r_period_cnt + 8'd1;
        end
    end

    assign period_cnt = r_period_cnt;
`endif

    assign count    = r_count;
    assign tc_pulse = r_tc;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
